// File: rtl/spw_buffer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spw_pkg
//  Description : Shared constants, typedefs and the free-entry priority
//                encoder for the store-pending-write buffer controller.
//  Contents    : PTR_WIDTH / DEPTH, spw_ptr_t, spw_cnt_t, lowest_zero()
//  Revision    : 1.0 - initial release
// ============================================================================
package spw_pkg;

  localparam int PTR_WIDTH = 3;
  localparam int DEPTH     = 1 << PTR_WIDTH;

  typedef logic [PTR_WIDTH-1:0] spw_ptr_t;
  typedef logic [PTR_WIDTH:0]   spw_cnt_t;

  // Lowest index whose bit is clear. Returns 0 when every bit is set; the
  // caller masks that case with the full flag.
  function automatic spw_ptr_t lowest_zero(input logic [DEPTH-1:0] v);
    spw_ptr_t idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!v[i]) idx = spw_ptr_t'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spw_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : spw_buffer_ctrl_if
//  Description : Bundle of the allocation, write and drain signals of the
//                spw buffer controller.
//  Ports       : slave  - controller side (receives requests / drain_ready)
//                master - store pipes + downstream side
//  Revision    : 1.0 - initial release
// ============================================================================
interface spw_buffer_ctrl_if import spw_pkg::*; ();

  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic             wr_en_o;
  spw_ptr_t         write_ptr_o;
  logic             drain_valid_o;
  spw_ptr_t         drain_ptr_o;
  logic             drain_ready_i;
  logic [DEPTH-1:0] valid_array_o;
  spw_cnt_t         count_o;
  logic             full_o;
  logic             empty_o;

  modport slave (
    input  req_valid_i,
    input  drain_ready_i,
    output req_ready_o,
    output wr_en_o,
    output write_ptr_o,
    output drain_valid_o,
    output drain_ptr_o,
    output valid_array_o,
    output count_o,
    output full_o,
    output empty_o
  );

  modport master (
    output req_valid_i,
    output drain_ready_i,
    input  req_ready_o,
    input  wr_en_o,
    input  write_ptr_o,
    input  drain_valid_o,
    input  drain_ptr_o,
    input  valid_array_o,
    input  count_o,
    input  full_o,
    input  empty_o
  );

endinterface
`default_nettype wire

// File: rtl/spw_buffer_ctrl_order_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spw_order_fifo
//  Description : DEPTH x PTR_WIDTH FIFO of allocated entry indices, giving
//                the drain order (allocation order).
//  Ports       : clk_i, rst_i (async, active-low)
//                push_i / push_data_i - enqueue an allocated index
//                pop_i                - dequeue the head
//                head_o               - oldest enqueued index
//  Revision    : 1.0 - initial release
// ============================================================================
module spw_order_fifo import spw_pkg::*; (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  input  wire logic     push_i,
  input  wire spw_ptr_t push_data_i,
  input  wire logic     pop_i,
  output spw_ptr_t      head_o
);

  spw_ptr_t r_mem [DEPTH];
  spw_ptr_t r_wr_ptr;
  spw_ptr_t r_rd_ptr;

  // Pointers wrap naturally modulo DEPTH; occupancy is tracked by the
  // owner's counter, so no extra wrap bit is kept here.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + spw_ptr_t'(1);
      if (pop_i)  r_rd_ptr <= r_rd_ptr + spw_ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= push_data_i;
  end

  assign head_o = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/spw_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spw_buffer_ctrl
//  Description : Allocation and drain controller for the spw buffer. Grants
//                one of two store requesters a free entry per cycle, owns the
//                per-entry valid bits and drains entries in allocation order.
//  Ports       : clk_i  - clock
//                rst_i  - asynchronous active-low reset
//                bus    - spw_buffer_ctrl_if.slave (requests, write port,
//                         drain handshake, valid array, count, full/empty)
//  Revision    : 1.0 - initial release
// ============================================================================
module spw_buffer_ctrl import spw_pkg::*; (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  spw_buffer_ctrl_if.slave  bus
);

  logic [DEPTH-1:0] r_valid;
  spw_cnt_t         r_count;
  logic             r_rr;       // requester that wins the next contention

  logic [DEPTH-1:0] w_valid_nxt;
  logic [1:0]       w_grant;
  logic             w_alloc;
  logic             w_drain;
  logic             w_full;
  logic             w_empty;
  spw_ptr_t         w_free_idx;
  spw_ptr_t         w_head;

  assign w_full     = (r_count == spw_cnt_t'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_free_idx = lowest_zero(r_valid);

  // Grants only ever go to a valid requester, so the grant vector is
  // already the AND of request and ready. Full blocks allocation even when
  // a drain completes this cycle: the freed slot is not visible until the
  // valid array updates.
  always_comb begin
    w_grant = 2'b00;
    if (!w_full) begin
      case (bus.req_valid_i)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_rr ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_alloc = |(bus.req_valid_i & w_grant);
  assign w_drain = !w_empty && bus.drain_ready_i;

  // The allocated index is clear and the drained head is set, so the two
  // updates can never target the same entry.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_alloc) w_valid_nxt[w_free_idx] = 1'b1;
    if (w_drain) w_valid_nxt[w_head]     = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      r_count <= '0;
      r_rr    <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      case ({w_alloc, w_drain})
        2'b10:   r_count <= r_count + spw_cnt_t'(1);
        2'b01:   r_count <= r_count - spw_cnt_t'(1);
        default: r_count <= r_count;
      endcase
      // After a grant, priority passes to the requester that did not win.
      if (w_alloc) r_rr <= w_grant[0];
    end
  end

  spw_order_fifo u_order_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_alloc),
    .push_data_i (w_free_idx),
    .pop_i       (w_drain),
    .head_o      (w_head)
  );

  assign bus.req_ready_o   = w_grant;
  assign bus.wr_en_o       = w_alloc;
  assign bus.write_ptr_o   = w_free_idx;
  assign bus.drain_valid_o = !w_empty;
  assign bus.drain_ptr_o   = w_head;
  assign bus.valid_array_o = r_valid;
  assign bus.count_o       = r_count;
  assign bus.full_o        = w_full;
  assign bus.empty_o       = w_empty;

endmodule
`default_nettype wire
